// File: rtl/ovrd_pregain_ramp.sv
// Drive/pre-gain stage ahead of the overdrive clamp: sample * gain, floor-shift, saturate, 2-cycle latency.
// Optional gain slewing is enabled with `define OVRD_GAIN_RAMP_EN (default build applies i_gain directly).
module ovrd_pregain_ramp #(
    parameter int fxp_size  = 32,
    parameter int gain_size = 16,
    parameter int gain_frac = 8,
    parameter int ramp_step = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [fxp_size-1:0]  i_sample,
    input  logic                 i_valid,
    input  logic [gain_size-1:0] i_gain,
    output logic [fxp_size-1:0]  o_sample,
    output logic                 o_valid,
    output logic                 o_clip
);

    localparam int PROD_W = fxp_size + gain_size + 1;

    // Returns {clip, sample}: floor-shifted product saturated to the fxp range.
    function automatic logic [fxp_size:0] saturate(input logic signed [PROD_W-1:0] prod);
        logic signed [PROD_W-1:0]     sh;
        logic [PROD_W-fxp_size:0]     upper;
        logic [fxp_size:0]            res;
        sh    = prod >>> gain_frac;
        upper = sh[PROD_W-1:fxp_size-1];
        if ((&upper) || !(|upper)) begin
            res = {1'b0, sh[fxp_size-1:0]};
        end else if (sh[PROD_W-1]) begin
            res = {1'b1, 1'b1, {(fxp_size-1){1'b0}}};
        end else begin
            res = {1'b1, 1'b0, {(fxp_size-1){1'b1}}};
        end
        return res;
    endfunction

    logic [gain_size-1:0]      mult_gain_s;
    logic signed [PROD_W-1:0]  prod_s;
    logic signed [PROD_W-1:0]  prod_r;
    logic                      valid1_r;
    logic [fxp_size:0]         sat_s;

`ifdef OVRD_GAIN_RAMP_EN
    localparam logic [gain_size-1:0] STEP = gain_size'(ramp_step);

    logic [gain_size-1:0] cur_gain_r;
    logic [gain_size-1:0] next_gain_s;
    logic [gain_size-1:0] diff_s;

    // Slew toward the requested gain by at most STEP, landing exactly on target.
    always_comb begin
        diff_s      = {gain_size{1'b0}};
        next_gain_s = cur_gain_r;
        if (cur_gain_r < i_gain) begin
            diff_s      = i_gain - cur_gain_r;
            next_gain_s = (diff_s > STEP) ? (cur_gain_r + STEP) : i_gain;
        end else if (cur_gain_r > i_gain) begin
            diff_s      = cur_gain_r - i_gain;
            next_gain_s = (diff_s > STEP) ? (cur_gain_r - STEP) : i_gain;
        end else begin
            next_gain_s = cur_gain_r;
        end
    end

    // Applied gain register; frozen between input strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_gain_r <= {gain_size{1'b0}};
        end else if (i_valid) begin
            cur_gain_r <= next_gain_s;
        end else begin
            cur_gain_r <= cur_gain_r;
        end
    end

    assign mult_gain_s = cur_gain_r;
`else
    assign mult_gain_s = i_gain;
`endif

    // Zero-extending the gain makes the low PROD_W bits of this product the signed product.
    assign prod_s = $signed({{(PROD_W-fxp_size){i_sample[fxp_size-1]}}, i_sample}
                          * {{(PROD_W-gain_size){1'b0}}, mult_gain_s});
    assign sat_s  = saturate(prod_r);

    // Stage 1: capture the raw product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_r   <= {PROD_W{1'b0}};
            valid1_r <= 1'b0;
        end else begin
            valid1_r <= i_valid;
            if (i_valid) begin
                prod_r <= prod_s;
            end else begin
                prod_r <= prod_r;
            end
        end
    end

    // Stage 2: saturate and register outputs; o_sample holds while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_sample <= {fxp_size{1'b0}};
            o_valid  <= 1'b0;
            o_clip   <= 1'b0;
        end else begin
            o_valid <= valid1_r;
            if (valid1_r) begin
                o_sample <= sat_s[fxp_size-1:0];
                o_clip   <= sat_s[fxp_size];
            end else begin
                o_sample <= o_sample;
                o_clip   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ovrd_pregain_ramp.sv
// Scoreboard bench for ovrd_pregain_ramp: model predicts each output at drive time, monitor pops on o_valid.
// Honours OVRD_GAIN_RAMP_EN to pick the ramped or direct gain model.
module tb_ovrd_pregain_ramp;

    logic        clk;
    logic        rst_n;
    logic [31:0] i_sample;
    logic        i_valid;
    logic [15:0] i_gain;
    logic [31:0] o_sample;
    logic        o_valid;
    logic        o_clip;

    int tests_run;
    int tests_failed;
    int run_len;
    int max_run;
    int model_gain;
    logic [32:0] sb[$];

    ovrd_pregain_ramp dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_sample (i_sample),
        .i_valid  (i_valid),
        .i_gain   (i_gain),
        .o_sample (o_sample),
        .o_valid  (o_valid),
        .o_clip   (o_clip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        tests_run = tests_run + 1;
        if (obs !== exp) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Reference: {clip, sample} from a 64-bit product, floor shift and clamp.
    function automatic logic [32:0] model(input int s, input int g);
        longint p;
        longint sh;
        p  = longint'(s) * longint'(g);
        sh = p >>> 8;
        if (sh > 64'sd2147483647)       return {1'b1, 32'h7FFF_FFFF};
        else if (sh < -64'sd2147483648) return {1'b1, 32'h8000_0000};
        else                            return {1'b0, sh[31:0]};
    endfunction

    task automatic send(input int s, input int g);
        int used;
        @(posedge clk);
        #1;
        i_sample = s;
        i_gain   = g[15:0];
        i_valid  = 1'b1;
`ifdef OVRD_GAIN_RAMP_EN
        used = model_gain;
        if (model_gain < g)      model_gain = (g - model_gain > 64) ? model_gain + 64 : g;
        else if (model_gain > g) model_gain = (model_gain - g > 64) ? model_gain - 64 : g;
        else                     model_gain = model_gain;
`else
        used = g;
`endif
        sb.push_back(model(s, used));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            i_valid = 1'b0;
        end
    endtask

    // Monitor: compare popped expectations, flag spurious valids and stray clip.
    always @(negedge clk) begin
        logic [32:0] e;
        if (rst_n) begin
            if (o_valid) begin
                run_len = run_len + 1;
                if (run_len > max_run) max_run = run_len;
                if (sb.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("o_sample", $signed(o_sample), $signed(e[31:0]));
                    check("o_clip", o_clip, e[32]);
                end
            end else begin
                run_len = 0;
                if (o_clip) check("clip_idle", o_clip, 0);
            end
        end else begin
            run_len = 0;
        end
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        run_len      = 0;
        max_run      = 0;
        model_gain   = 0;
        i_sample     = 32'd0;
        i_valid      = 1'b0;
        i_gain       = 16'd0;
        rst_n        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_o_sample", o_sample, 0);
        check("reset_o_valid", o_valid, 0);
        check("reset_o_clip", o_clip, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Ramp-up from mute at unity target (or instant unity without ramp).
        for (int k = 0; k < 6; k++) send(1000, 16'h0100);
        idle(3);

        // Floor rounding at half gain.
        for (int k = 0; k < 4; k++) send(0, 16'h0080);
        send(-3, 16'h0080);
        send(3, 16'h0080);
        idle(1);

        // Saturation at gain 2.0.
        for (int k = 0; k < 8; k++) send(0, 16'h0200);
        send(32'sh4000_0000, 16'h0200);
        send(-32'sh4000_0001, 16'h0200);
        send(32'sh3FFF_FFFF, 16'h0200);
        send(-32'sh4000_0000, 16'h0200);
        idle(2);

        // Reversal mid-ramp, gaps freezing the gain, and the extremes of the gain word.
        send(12345, 16'hFFFF);
        send(12345, 16'hFFFF);
        idle(3);
        send(-777, 16'hFFFF);
        send(-777, 16'h0000);
        send(-777, 16'h0000);
        send(-777, 16'h0000);
        send(32'sh7FFF_FFFF, 16'h0030);
        send(32'sh7FFF_FFFF, 16'h0030);
        idle(3);

        // Throughput at settled unity gain.
        for (int k = 0; k < 8; k++) send(0, 16'h0100);
        idle(4);
        max_run = 0;
        for (int k = 0; k < 100; k++) send(int'($urandom), 16'h0100);
        idle(4);
        check("continuous_valid", max_run >= 100, 1);

        // Reset one cycle after a strobe: in-flight sample is dropped.
        send(5000, 16'h0100);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        rst_n   = 1'b0;
        #1;
        check("async_o_sample", o_sample, 0);
        check("async_o_valid", o_valid, 0);
        sb.delete();
        model_gain = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(5);
        send(1000, 16'h0100);
        send(1000, 16'h0100);
        idle(4);

        for (int k = 0; k < 10 && sb.size() != 0; k++) @(posedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
